// File: rtl/wb_queue.sv
// Writeback queue between execute and the register-file write port: in-order buffer,
// one drain per cycle, optional forwarding lookup compiled in with WB_FWD_EN.
module wb_queue #(
  parameter  int DEPTH  = 4,
  parameter  int IDX_W  = 3,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_dst_idx,
  input  logic [DATA_W-1:0] in_val,
  input  logic              wb_stall,
  output logic              wb_we,
  output logic [IDX_W-1:0]  wb_dst_idx,
  output logic [DATA_W-1:0] wb_val,
  input  logic [IDX_W-1:0]  q1_idx,
  input  logic [IDX_W-1:0]  q2_idx,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q1_val,
  output logic [DATA_W-1:0] q2_val,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, nonempty;

  assign nonempty   = (count_q != '0) && !rst;
  // Ready depends only on registered occupancy: a full queue never passes through.
  assign in_ready   = (count_q < CNT_W'(DEPTH)) && !rst;
  assign wb_we      = nonempty && !wb_stall;
  assign wb_dst_idx = nonempty ? mem_q[head_q].idx : '0;
  assign wb_val     = nonempty ? mem_q[head_q].val : '0;
  assign count      = count_q;

  assign push = in_valid && in_ready;
  assign pop  = wb_we;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= '{idx: in_dst_idx, val: in_val};
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    q1_val = '0;
    q2_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && !rst) begin
        if (mem_q[head_q + PTR_W'(i)].idx == q1_idx) begin
          q1_hit = 1'b1;
          q1_val = mem_q[head_q + PTR_W'(i)].val;
        end
        if (mem_q[head_q + PTR_W'(i)].idx == q2_idx) begin
          q2_hit = 1'b1;
          q2_val = mem_q[head_q + PTR_W'(i)].val;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{q1_idx, q2_idx};
  assign q1_hit = 1'b0;
  assign q2_hit = 1'b0;
  assign q1_val = '0;
  assign q2_val = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional reset.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int IDX_W = 3;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, wb_stall, wb_we, q1_hit, q2_hit;
  logic [IDX_W-1:0] in_dst_idx, wb_dst_idx, q1_idx, q2_idx;
  logic [DW-1:0] in_val, wb_val, q1_val, q2_val;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dst_idx(in_dst_idx), .in_val(in_val), .wb_stall(wb_stall),
    .wb_we(wb_we), .wb_dst_idx(wb_dst_idx), .wb_val(wb_val),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_val(q1_val), .q2_val(q2_val), .count(count)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    val;
  } ent_t;

  ent_t        mq[$];
  logic [DW-1:0] rf_ref [8];
  logic [DW-1:0] rf_dut [8];
  int          vectors = 0;
  int          miscompares = 0;
  bit          e_push, e_pop;
  bit          d_we;
  logic [IDX_W-1:0] d_idx;
  logic [DW-1:0]    d_val;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fwd_ref(input logic [IDX_W-1:0] q, output bit hit, output logic [DW-1:0] v);
    hit = 0; v = '0;
    if (rst) return;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].idx == q) begin hit = 1; v = mq[i].val; break; end
  endfunction

  // Apply inputs after the falling edge, then compare every output to the model.
  task automatic drive(input bit r, input bit v, input logic [IDX_W-1:0] idx, input logic [DW-1:0] val,
                       input bit st, input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    bit exp_rdy, exp_we, h;
    logic [DW-1:0] fv;
    rst = r; in_valid = v; in_dst_idx = idx; in_val = val; wb_stall = st; q1_idx = a; q2_idx = b;
    #1;
    exp_rdy = !r && mq.size() < DEPTH;
    exp_we  = !r && mq.size() != 0 && !st;
    chk("in_ready", DW'(in_ready), DW'(exp_rdy));
    chk("wb_we", DW'(wb_we), DW'(exp_we));
    chk("count", DW'(count), DW'(mq.size()));
    chk("wb_dst_idx", DW'(wb_dst_idx), (!r && mq.size() != 0) ? DW'(mq[0].idx) : '0);
    chk("wb_val", wb_val, (!r && mq.size() != 0) ? mq[0].val : '0);
`ifdef WB_FWD_EN
    fwd_ref(a, h, fv);
    chk("q1_hit", DW'(q1_hit), DW'(h));
    chk("q1_val", q1_val, fv);
    fwd_ref(b, h, fv);
    chk("q2_hit", DW'(q2_hit), DW'(h));
    chk("q2_val", q2_val, fv);
`else
    chk("q1_hit", DW'(q1_hit), '0);
    chk("q1_val", q1_val, '0);
    chk("q2_hit", DW'(q2_hit), '0);
    chk("q2_val", q2_val, '0);
`endif
    e_push = v && exp_rdy;
    e_pop  = exp_we;
    d_we = wb_we; d_idx = wb_dst_idx; d_val = wb_val;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (d_we) rf_dut[d_idx] = d_val;
    if (rst) mq.delete();
    else begin
      if (e_pop) begin e = mq.pop_front(); rf_ref[e.idx] = e.val; end
      if (e_push) mq.push_back('{idx: in_dst_idx, val: in_val});
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit v, input logic [IDX_W-1:0] idx, input logic [DW-1:0] val,
                     input bit st);
    drive(r, v, idx, val, st, 3'd1, 3'd2);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf_ref[i] = 32'h0; rf_dut[i] = 32'h0; end
    rst = 1; in_valid = 0; in_dst_idx = 0; in_val = 0; wb_stall = 0; q1_idx = 0; q2_idx = 0;
    @(negedge clk);
    cyc(1, 1, 0, 32'h1, 0);
    drive(1, 0, 0, 0, 0, 1, 2);
    chk("rst_in_ready", DW'(in_ready), 32'd0);
    tick();

    // Single result: one cycle of latency, then written.
    drive(0, 1, 0, 32'hDEADBEEF, 0, 0, 2);
    chk("first_ready", DW'(in_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2);
    chk("lat_we", DW'(wb_we), 32'd1);
    chk("lat_val", wb_val, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2);
    chk("rf0", rf_dut[0], 32'hDEADBEEF);
    chk("drained_count", DW'(count), 32'd0);
    tick();

    // Fill under stall, fifth push refused.
    for (int i = 0; i < 4; i++) cyc(0, 1, 3'(i), 32'h10 + i, 1);
    drive(0, 1, 5, 32'h99, 1, 1, 2);
    chk("full_count", DW'(count), 32'd4);
    chk("full_ready", DW'(in_ready), 32'd0);
    tick();
    // Release with in_valid held: pop without pass-through, then push+pop.
    drive(0, 1, 6, 32'h77, 0, 1, 2);
    chk("full_pop_ready", DW'(in_ready), 32'd0);
    chk("drain0", wb_val, 32'h10);
    tick();
    drive(0, 1, 6, 32'h77, 0, 1, 2);
    chk("reopen_ready", DW'(in_ready), 32'd1);
    chk("drain1", wb_val, 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 1, 2);
    chk("pp_count", DW'(count), 32'd3);
    chk("drain2", wb_val, 32'h12);
    tick();
    drive(0, 0, 0, 0, 0, 1, 2);
    chk("drain3", wb_val, 32'h13);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Two writes to ECX under stall: youngest forwards, youngest lands.
    cyc(0, 1, 1, 32'hCAFEBABE, 1);
    cyc(0, 1, 1, 32'hBADF00D5, 1);
    drive(0, 0, 0, 0, 1, 1, 2);
`ifdef WB_FWD_EN
    chk("fwd_q1_hit", DW'(q1_hit), 32'd1);
    chk("fwd_q1_val", q1_val, 32'hBADF00D5);
`else
    chk("nofwd_q1_hit", DW'(q1_hit), 32'd0);
    chk("nofwd_q1_val", q1_val, 32'd0);
`endif
    chk("fwd_q2_hit", DW'(q2_hit), 32'd0);
    chk("fwd_q2_val", q2_val, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("ecx", rf_dut[1], 32'hBADF00D5);

    // Reset with three entries queued: nothing written.
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'(4 + i), 32'hA0 + i, 1);
    drive(1, 0, 0, 0, 0, 1, 2);
    chk("rst_busy_we", DW'(wb_we), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 2);
    chk("rst_busy_count", DW'(count), 32'd0);
    tick();
    chk("rst_busy_rf4", rf_dut[4], 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(99) == 0, $urandom_range(9) < 6, 3'($urandom), $urandom,
            $urandom_range(9) < 3, 3'($urandom), 3'($urandom));
      tick();
    end
    for (int i = 0; i < 8; i++) chk("rf_final", rf_dut[i], rf_ref[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue that sits between the execute stage and the register file's write port. Accepts completed results (destination index plus 32-bit value) over a valid/ready handshake, buffers them in order, and drains one per cycle onto the register file's `we`/`dst_idx`/`w_val` inputs. A forwarding lookup lets operand readers see values still queued and not yet written to EAX..EDI.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `IDX_W`, 3: register index width, matching the register file's `dst_idx`.
- `DATA_W`, 32: result width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: result offered.
- `in_ready` out 1: queue can accept this cycle.
- `in_dst_idx` in IDX_W: destination register of the result.
- `in_val` in DATA_W: result value.
- `wb_stall` in 1: register-file port unavailable; hold the head entry.
- `wb_we` out 1: drives the register file's `we`.
- `wb_dst_idx` out IDX_W: drives `dst_idx`.
- `wb_val` out DATA_W: drives `w_val`.
- `q1_idx`, `q2_idx` in IDX_W: forwarding query indices, tied to `src1_idx`/`src2_idx`.
- `q1_hit`, `q2_hit` out 1: a queued entry targets the queried index.
- `q1_val`, `q2_val` out DATA_W: value of the youngest matching entry.
- `count` out clog2(DEPTH+1): occupancy.

## Operation
- Circular buffer with head and tail pointers of width log2(DEPTH) and a separate occupancy counter. Pointers wrap modulo DEPTH.
- Push occurs when `in_valid && in_ready`. The entry is written at the tail and the tail advances.
- Pop occurs when `wb_we` is high. The head advances at the same edge on which the register file samples the write.
- Outputs `wb_we`, `wb_dst_idx` and `wb_val` are combinational from the head entry:
  - `wb_we = (count != 0) && !wb_stall && !rst`.
  - When the queue is empty, `wb_dst_idx` and `wb_val` are driven to 0.
- `in_ready = (count < DEPTH) && !rst`.
  - When full, a simultaneous pop does not open a slot in the same cycle (no pass-through).
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Results for the same index are written in arrival order, so the later value ends up in the register file.
- Forwarding (see Configuration):
  - The query compares against all valid entries, including the head being written this cycle.
  - The youngest match (closest to the tail) wins.
  - If there is no match, hit=0 and val=0.
  - Lookup is combinational.
- Reset while busy discards all queued entries and does not write them.

## Timing
- Reset values:
  - `count` = 0, head = 0, tail = 0.
  - `wb_we` = 0, `wb_dst_idx` = 0, `wb_val` = 0.
  - `q*_hit` = 0, `q*_val` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` deasserts.
- Latency: a result accepted at edge N appears at the head after N. If not stalled, `wb_we` is high during cycle N→N+1 and the register file holds the value after edge N+1. The minimum is one cycle, with no zero-cycle bypass.
- Throughput is one push and one pop per cycle.
- While `wb_stall` is high the head entry is held stable and pushes continue until the queue is full.
- `in_dst_idx` and `in_val` are sampled only on an accepted push.

## Configuration
- `WB_FWD_EN` defined: the forwarding comparators and the youngest-match priority logic are compiled in as described.
- Undefined: `q1_hit`, `q2_hit`, `q1_val` and `q2_val` are tied to 0 and the comparators are removed. Readers must then stall on a scoreboard outside this block.

## Test plan
- Reset, then push idx 0 with 0xDEADBEEF.
  - The next cycle shows `wb_we`=1, `wb_dst_idx`=0, `wb_val`=0xDEADBEEF.
  - The register file's `regfile_out1` (src1=0) reads 0xDEADBEEF one edge later and `count` returns to 0.
- Hold `wb_stall`=1 and push 4 entries (idx 0..3, values 0x10..0x13).
  - `count`=4, `in_ready`=0, and a fifth push is not accepted.
  - After releasing the stall, the entries drain in order 0x10..0x13 over 4 consecutive cycles.
- With the queue full, assert `in_valid` with a pop in the same cycle.
  - No push is taken that cycle.
  - The next cycle shows `in_ready`=1, and push and pop together keep `count` at 3.
- With `WB_FWD_EN` defined and the stall held, push idx 1 = 0xCAFEBABE, then idx 1 = 0xBADF00D5, and set `q1_idx`=1, `q2_idx`=2.
  - Expect `q1_hit`=1, `q1_val`=0xBADF00D5, `q2_hit`=0, `q2_val`=0.
  - After the drain, ECX holds 0xBADF00D5.
- With 3 entries queued, assert `rst` for one cycle.
  - `wb_we` never pulses, `count`=0, and the register file retains its prior contents.
- Build without `WB_FWD_EN`, repeat the forwarding scenario: all `q*_hit` and `q*_val` stay 0, and the drain order is unchanged.
